// File: rtl/demux_pkg.sv
// Shared constants and FSM encoding for the 4-slot TDM demultiplexer.
package demux_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Slot counter advance; wraps modulo NUM_SLOTS through natural overflow.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return s + 1'b1;
  endfunction

endpackage

// File: rtl/demux1to4.sv
// One-hot decode of the active slot into per-slot write enables.
module demux1to4
  import demux_pkg::*;
(
  input  logic [SLOT_W-1:0]    slot,
  input  logic                 strobe,
  output logic [NUM_SLOTS-1:0] we
);

  always_comb begin
    we = '0;
    if (strobe) we[slot] = 1'b1;
  end

endmodule

// File: rtl/demux_tdm4.sv
// Frame-aligned 4-slot TDM demultiplexer with HUNT/LOCK sync tracking.
// Slots 0..2 park in shadow registers; the slot-3 strobe commits the whole frame to q.
module demux_tdm4
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       strobe,
  input  logic                       sync,
  output logic [NUM_SLOTS*WIDTH-1:0] q,
  output logic                       frame_valid,
  output logic [SLOT_W-1:0]          slot,
  output logic                       locked,
  output logic                       sync_err
);

  state_t                            state, state_nx;
  logic [SLOT_W-1:0]                 slot_nx;
  logic                              err_nx;
  logic                              wr_en;
  logic [SLOT_W-1:0]                 wr_sel;
  logic [NUM_SLOTS-1:0]              we;
  logic [NUM_SLOTS-2:0][WIDTH-1:0]   shadow;

  // Next-state / write-target decision; nothing moves without a strobe.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    err_nx   = 1'b0;
    wr_en    = 1'b0;
    wr_sel   = '0;
    if (strobe) begin
      case (state)
        HUNT: begin
          if (sync) begin
            wr_en    = 1'b1;
            slot_nx  = SLOT_W'(1);
            state_nx = LOCK;
          end
        end
        LOCK: begin
          if (sync) begin
            // Sync always restarts a frame at slot 0; early sync also flags an error.
            wr_en   = 1'b1;
            slot_nx = SLOT_W'(1);
            err_nx  = (slot != '0);
          end else if (slot == '0) begin
            err_nx   = 1'b1;
            slot_nx  = '0;
            state_nx = HUNT;
          end else begin
            wr_en   = 1'b1;
            wr_sel  = slot;
            slot_nx = next_slot(slot);
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  demux1to4 u_dec (
    .slot   (wr_sel),
    .strobe (wr_en),
    .we     (we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      slot        <= '0;
      sync_err    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      sync_err    <= err_nx;
      frame_valid <= we[NUM_SLOTS-1];
    end
  end

  assign locked = (state == LOCK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS-1; k++)
        if (we[k]) shadow[k] <= din;
    end
  end

  // The last slot bypasses the shadow so q updates on the same edge it arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                q <= '0;
    else if (we[NUM_SLOTS-1]) q <= {din, shadow};
  end

endmodule

// File: doc/demux_tdm4.md
DEMUX_TDM4 -- requirements
Module: demux_tdm4

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning the bit width of one slot's data.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 SHALL have port din, input, WIDTH bits: time-multiplexed slot data.
REQ-005 SHALL have port strobe, input, 1 bit: din and sync are valid this cycle.
REQ-006 SHALL have port sync, input, 1 bit: the current strobe carries slot 0.
REQ-007 SHALL have port q, output, 4*WIDTH bits: the last complete frame, with slot k in q[k*WIDTH +: WIDTH].
REQ-008 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when q updates.
REQ-009 SHALL have port slot, output, 2 bits: the slot index expected on the next strobe.
REQ-010 SHALL have port locked, output, 1 bit: high in LOCK state.
REQ-011 SHALL have port sync_err, output, 1 bit: one-cycle pulse on a framing violation.

Function
REQ-012 SHALL implement the two-state FSM HUNT/LOCK; cycles without strobe change no state, counter or shadow register.
REQ-013 In HUNT, a strobe with sync=0 SHALL be discarded with no output change.
REQ-014 In HUNT, a strobe with sync=1 SHALL store din in shadow slot 0, set slot=1 and enter LOCK.
REQ-015 In LOCK, a strobe with sync=0 at slot 1..3 SHALL store din in shadow[slot] and increment slot.
REQ-016 Slot 3 to slot 0 SHALL wrap modulo 4.
REQ-017 In LOCK, a strobe at slot 0 with sync=1 SHALL store din in shadow 0 and set slot=1.
REQ-018 In LOCK, a strobe at slot 0 with sync=0 SHALL pulse sync_err, discard din and return to HUNT with slot=0.
REQ-019 In LOCK, a strobe at slot 1..3 with sync=1 SHALL pulse sync_err, discard the partial frame, store din in shadow 0 and set slot=1, remaining in LOCK.
REQ-020 On the edge sampling a valid slot-3 strobe, q SHALL load shadow slots 0..2 plus din, and frame_valid SHALL be high for exactly the following cycle (1-edge latency).
REQ-021 q SHALL hold its value between frame completions, including across HUNT periods.
REQ-022 A partial frame SHALL never reach q.
REQ-023 frame_valid and sync_err SHALL never assert in the same cycle.
REQ-024 Back-to-back strobes on every cycle SHALL be supported with no lost slots, giving frame_valid every 4th cycle.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Reset assertion SHALL immediately force state=HUNT, slot=0, q=0, shadow=0, frame_valid=0, sync_err=0 and locked=0.
REQ-027 Reset mid-frame SHALL discard the partial frame.
REQ-028 The first strobe after reset deassertion SHALL be evaluated per REQ-013/014.

Structure
REQ-029 Shared package demux_pkg SHALL hold NUM_SLOTS=4, SLOT_W=2 and the HUNT/LOCK state encodings.
REQ-030 A combinational sub-module demux1to4 SHALL decode slot and strobe into four one-hot shadow-register write enables.

Verification
REQ-031 Reset, then strobes with sync=1,0,0,0 and din=1,0,1,1 (WIDTH=1) -> q=4'b1101, one frame_valid pulse, locked=1.
REQ-032 Continuous strobes carrying two frames (A,B,C,D then E,F,G,H, WIDTH=4) -> frame_valid exactly 4 cycles apart, with q=HGFE after the second frame.
REQ-033 Sync=1 at slot 2 mid-frame -> sync_err pulse, q unchanged, next 3 strobes complete a frame starting from that slot-0 data.
REQ-034 Strobe with sync=0 at expected slot 0 -> sync_err pulse, locked=0, subsequent sync=0 strobes ignored until sync=1.
REQ-035 Reset asserted after slot 2 of a frame -> q=0, slot=0, locked=0 immediately, and no frame_valid for that frame.
REQ-036 Strobe low for 10 cycles mid-frame, then remaining slots -> frame completes correctly with no error.
